// File: rtl/retire_trace_buffer.sv
// Retire-trace capture FIFO: tags each retired instruction with a sequence number
// and a taken-flow flag, then holds it for a valid/ready consumer.
module retire_trace_buffer #(
  parameter int XLEN      = 32,
  parameter int DEPTH     = 16,
  parameter int SEQ_W     = 16,
  parameter int OVERWRITE = 0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      enable,
  input  logic                      clear,
  input  logic                      cap_valid,
  input  logic [XLEN-1:0]           cap_pc,
  input  logic [XLEN-1:0]           cap_next_pc,
  input  logic [31:0]               cap_ins,
  input  logic [4:0]                cap_rd,
  input  logic [XLEN-1:0]           cap_result,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [SEQ_W-1:0]          out_seq,
  output logic [XLEN-1:0]           out_pc,
  output logic [XLEN-1:0]           out_next_pc,
  output logic [XLEN-1:0]           out_result,
  output logic [31:0]               out_ins,
  output logic [4:0]                out_rd,
  output logic                      out_taken,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      full,
  output logic                      empty,
  output logic [15:0]               overflow_cnt
);

  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = AW + 1;
  localparam bit OVW = (OVERWRITE != 0);

  typedef struct packed {
    logic [SEQ_W-1:0] seq;
    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  next_pc;
    logic [31:0]      ins;
    logic [4:0]       rd;
    logic [XLEN-1:0]  result;
    logic             taken;
  } rec_t;

  rec_t             mem [DEPTH];
  rec_t             new_rec;
  rec_t             head;
  logic [AW-1:0]    wp;
  logic [AW-1:0]    rp;
  logic [CW-1:0]    cnt;
  logic [SEQ_W-1:0] seq_cnt;

  logic cap_evt;
  logic is_full;
  logic is_empty;
  logic do_pop;
  logic do_push;
  logic lost;
  logic do_ovw;
  logic do_write;
  logic adv_rp;

  // Output handshake: a record transfers on a rising edge where out_valid and
  // out_ready are both high; out_valid never depends on out_ready in the same
  // cycle, and out_ready while out_valid is low is ignored.
  always_comb begin
    is_empty = (cnt == '0);
    is_full  = (cnt == CW'(DEPTH));
    cap_evt  = cap_valid & enable;
    do_pop   = out_ready & ~is_empty;
    // A full buffer still accepts a record when the head leaves in the same cycle.
    do_push  = cap_evt & (~is_full | do_pop);
    lost     = cap_evt & is_full & ~do_pop;
    do_ovw   = lost & OVW;
    do_write = do_push | do_ovw;
    adv_rp   = do_pop | do_ovw;
  end

  always_comb begin
    new_rec         = '0;
    new_rec.seq     = seq_cnt;
    new_rec.pc      = cap_pc;
    new_rec.next_pc = cap_next_pc;
    new_rec.ins     = cap_ins;
    new_rec.rd      = cap_rd;
    new_rec.result  = cap_result;
    new_rec.taken   = (cap_next_pc != (cap_pc + XLEN'(4)));
  end

  // Storage array resets to zero so the head fields read 0 out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (!clear && do_write) begin
      mem[wp] <= new_rec;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
    end else if (clear) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (do_write) wp <= wp + AW'(1);
      if (adv_rp)   rp <= rp + AW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else begin
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Every event burns a sequence number, so dropped records show up as gaps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seq_cnt      <= '0;
      overflow_cnt <= '0;
    end else if (clear) begin
      seq_cnt      <= '0;
      overflow_cnt <= '0;
    end else begin
      if (cap_evt) seq_cnt <= seq_cnt + SEQ_W'(1);
      if (lost && (overflow_cnt != 16'hFFFF)) overflow_cnt <= overflow_cnt + 16'd1;
    end
  end

  always_comb begin
    head        = mem[rp];
    out_valid   = ~is_empty;
    out_seq     = head.seq;
    out_pc      = head.pc;
    out_next_pc = head.next_pc;
    out_ins     = head.ins;
    out_rd      = head.rd;
    out_result  = head.result;
    out_taken   = head.taken;
    count       = cnt;
    full        = is_full;
    empty       = is_empty;
  end

endmodule

// File: tb/tb_retire_trace_buffer.sv
// Bench for retire_trace_buffer: one drop-mode and one overwrite-mode instance
// share the same stimulus; a queue scoreboard plus directed checks.
module tb_retire_trace_buffer;

  localparam int XLEN  = 32;
  localparam int DEPTH = 16;
  localparam int SEQ_W = 16;
  localparam int CW    = $clog2(DEPTH) + 1;
  localparam int RW    = SEQ_W + 3 * XLEN + 32 + 5 + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic enable = 1'b0;
  logic clear = 1'b0;
  logic cap_valid = 1'b0;
  logic out_ready = 1'b0;
  logic [XLEN-1:0] cap_pc = '0;
  logic [XLEN-1:0] cap_next_pc = '0;
  logic [XLEN-1:0] cap_result = '0;
  logic [31:0]     cap_ins = '0;
  logic [4:0]      cap_rd = '0;

  logic v0, v1, tk0, tk1, full0, full1, empty0, empty1;
  logic [SEQ_W-1:0] seq0, seq1;
  logic [XLEN-1:0]  pc0, pc1, npc0, npc1, res0, res1;
  logic [31:0]      ins0, ins1;
  logic [4:0]       rd0, rd1;
  logic [CW-1:0]    cnt0, cnt1;
  logic [15:0]      ovf0, ovf1;
  logic [RW-1:0]    rec0, rec1;

  assign rec0 = {seq0, pc0, npc0, ins0, rd0, res0, tk0};
  assign rec1 = {seq1, pc1, npc1, ins1, rd1, res1, tk1};

  retire_trace_buffer #(.XLEN(XLEN), .DEPTH(DEPTH), .SEQ_W(SEQ_W), .OVERWRITE(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .clear(clear), .cap_valid(cap_valid),
    .cap_pc(cap_pc), .cap_next_pc(cap_next_pc), .cap_ins(cap_ins), .cap_rd(cap_rd),
    .cap_result(cap_result), .out_valid(v0), .out_ready(out_ready), .out_seq(seq0),
    .out_pc(pc0), .out_next_pc(npc0), .out_result(res0), .out_ins(ins0), .out_rd(rd0),
    .out_taken(tk0), .count(cnt0), .full(full0), .empty(empty0), .overflow_cnt(ovf0)
  );

  retire_trace_buffer #(.XLEN(XLEN), .DEPTH(DEPTH), .SEQ_W(SEQ_W), .OVERWRITE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .clear(clear), .cap_valid(cap_valid),
    .cap_pc(cap_pc), .cap_next_pc(cap_next_pc), .cap_ins(cap_ins), .cap_rd(cap_rd),
    .cap_result(cap_result), .out_valid(v1), .out_ready(out_ready), .out_seq(seq1),
    .out_pc(pc1), .out_next_pc(npc1), .out_result(res1), .out_ins(ins1), .out_rd(rd1),
    .out_taken(tk1), .count(cnt1), .full(full1), .empty(empty1), .overflow_cnt(ovf1)
  );

  // Clock
  always #5 clk = ~clk;

  // Scoreboard state
  logic [RW-1:0]    exp_q0[$];
  logic [RW-1:0]    exp_q1[$];
  logic [15:0]      ovf_m0 = '0;
  logic [15:0]      ovf_m1 = '0;
  logic [SEQ_W-1:0] seq_m = '0;
  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] npc;
    logic            exp_taken;
  } vec_t;
  vec_t tbl [8];

  task automatic chk(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_dut(input string tag, input logic v, input logic [CW-1:0] c,
                           input logic f, input logic e, input logic [15:0] o,
                           input logic [RW-1:0] rec, input int size,
                           input logic [15:0] o_m, input logic [RW-1:0] head_m);
    chk({tag, "_valid"}, RW'(v), RW'(size != 0));
    chk({tag, "_count"}, RW'(c), RW'(size));
    chk({tag, "_full"},  RW'(f), RW'(size == DEPTH));
    chk({tag, "_empty"}, RW'(e), RW'(size == 0));
    chk({tag, "_ovf"},   RW'(o), RW'(o_m));
    if (size != 0) chk({tag, "_head"}, rec, head_m);
  endtask

  task automatic check_state();
    check_dut("d0", v0, cnt0, full0, empty0, ovf0, rec0, exp_q0.size(), ovf_m0,
              (exp_q0.size() != 0) ? exp_q0[0] : '0);
    check_dut("d1", v1, cnt1, full1, empty1, ovf1, rec1, exp_q1.size(), ovf_m1,
              (exp_q1.size() != 0) ? exp_q1[0] : '0);
  endtask

  task automatic model_reset();
    exp_q0.delete();
    exp_q1.delete();
    ovf_m0 = '0;
    ovf_m1 = '0;
    seq_m  = '0;
  endtask

  // Driver: applies one cycle of stimulus, updates the model, checks after the edge.
  task automatic cycle(input bit ev, input bit en, input bit rdy, input bit clr,
                       input logic [XLEN-1:0] pc, input logic [XLEN-1:0] npc,
                       input logic [31:0] ins, input logic [4:0] rd,
                       input logic [XLEN-1:0] res);
    logic [RW-1:0] r;
    bit full_m0, full_m1, pop0, pop1;
    cap_valid = ev; enable = en; out_ready = rdy; clear = clr;
    cap_pc = pc; cap_next_pc = npc; cap_ins = ins; cap_rd = rd; cap_result = res;
    r = {seq_m, pc, npc, ins, rd, res, (npc != pc + 32'd4)};
    @(posedge clk);
    #1;
    if (clr) begin
      model_reset();
    end else begin
      full_m0 = (exp_q0.size() == DEPTH);
      full_m1 = (exp_q1.size() == DEPTH);
      pop0 = rdy && (exp_q0.size() != 0);
      pop1 = rdy && (exp_q1.size() != 0);
      if (pop0) void'(exp_q0.pop_front());
      if (pop1) void'(exp_q1.pop_front());
      if (ev && en) begin
        if (!full_m0 || pop0) exp_q0.push_back(r);
        else if (ovf_m0 != 16'hFFFF) ovf_m0++;
        if (!full_m1 || pop1) begin
          exp_q1.push_back(r);
        end else begin
          void'(exp_q1.pop_front());
          exp_q1.push_back(r);
          if (ovf_m1 != 16'hFFFF) ovf_m1++;
        end
        seq_m++;
      end
    end
    cap_valid = 1'b0; out_ready = 1'b0; clear = 1'b0; enable = 1'b1;
    check_state();
  endtask

  task automatic push_ev(input logic [XLEN-1:0] pc, input logic [XLEN-1:0] npc, input bit rdy);
    cycle(1'b1, 1'b1, rdy, 1'b0, pc, npc, $urandom(), 5'($urandom_range(0, 31)), $urandom());
  endtask

  task automatic idle(input bit rdy);
    cycle(1'b0, 1'b1, rdy, 1'b0, '0, '0, '0, '0, '0);
  endtask

  initial begin
    tbl[0] = '{32'h0000_0100, 32'h0000_0104, 1'b0};
    tbl[1] = '{32'h0000_0104, 32'h0000_0108, 1'b0};
    tbl[2] = '{32'h0000_0108, 32'h0000_010C, 1'b0};
    tbl[3] = '{32'h0000_010C, 32'h0000_0110, 1'b0};
    tbl[4] = '{32'h0000_0110, 32'h0000_0114, 1'b0};
    tbl[5] = '{32'h0000_0200, 32'h0000_0240, 1'b1};
    tbl[6] = '{32'hFFFF_FFFC, 32'h0000_0000, 1'b0};
    tbl[7] = '{32'h0000_0300, 32'h0000_0300, 1'b1};

    // Reset
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst_valid", RW'(v0), RW'(0));
    chk("rst_empty", RW'(empty0), RW'(1));
    chk("rst_count", RW'(cnt0), RW'(0));
    chk("rst_ovf", RW'(ovf0), RW'(0));
    chk("rst_data", rec0, '0);
    idle(1'b1);

    // Table: sequential, branch and wrap-around records, no drain
    for (int i = 0; i < 8; i++) begin
      push_ev(tbl[i].pc, tbl[i].npc, 1'b0);
      if (i == 4) chk("five_count", RW'(cnt0), RW'(5));
    end
    for (int i = 0; i < 8; i++) begin
      chk("tbl_seq", RW'(seq0), RW'(i));
      chk("tbl_pc", RW'(pc0), RW'(tbl[i].pc));
      chk("tbl_taken0", RW'(tk0), RW'(tbl[i].exp_taken));
      chk("tbl_taken1", RW'(tk1), RW'(tbl[i].exp_taken));
      idle(1'b1);
    end

    // Overflow: 20 events into a 16-deep buffer after a flush
    cycle(1'b0, 1'b1, 1'b0, 1'b1, '0, '0, '0, '0, '0);
    for (int i = 0; i < 20; i++) push_ev(32'h1000 + 32'(i * 4), 32'h1004 + 32'(i * 4), 1'b0);
    chk("ovf_full", RW'(full0), RW'(1));
    chk("ovf_cnt0", RW'(ovf0), RW'(4));
    chk("ovf_cnt1", RW'(ovf1), RW'(4));
    chk("ovf_head0", RW'(seq0), RW'(0));
    chk("ovf_head1", RW'(seq1), RW'(4));

    // Full with push and pop together: nothing lost
    for (int i = 0; i < 10; i++) push_ev(32'h2000 + 32'(i * 4), 32'h2004 + 32'(i * 4), 1'b1);
    chk("pp_count", RW'(cnt0), RW'(16));
    chk("pp_ovf", RW'(ovf0), RW'(4));
    chk("pp_head0", RW'(seq0), RW'(10));
    chk("pp_head1", RW'(seq1), RW'(14));

    // cap_valid with enable low: no push, no sequence number consumed
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h3000, 32'h3004, '0, '0, '0);
    repeat (16) idle(1'b1);
    push_ev(32'h3000, 32'h3004, 1'b0);
    chk("en_seq", RW'(seq0), RW'(30));
    idle(1'b1);

    // Clear together with an event and a pop at count 7
    for (int i = 0; i < 7; i++) push_ev(32'h4000 + 32'(i * 4), 32'h4004 + 32'(i * 4), 1'b0);
    chk("clr_pre", RW'(cnt0), RW'(7));
    cycle(1'b1, 1'b1, 1'b1, 1'b1, 32'h5000, 32'h5004, '0, '0, '0);
    chk("clr_count", RW'(cnt0), RW'(0));
    chk("clr_empty", RW'(empty0), RW'(1));
    chk("clr_ovf1", RW'(ovf1), RW'(0));
    push_ev(32'h5000, 32'h5010, 1'b1);
    chk("clr_seq", RW'(seq0), RW'(0));
    idle(1'b1);

    // Push and pop in the same cycle while empty: record kept, count 1
    push_ev(32'h6000, 32'h6004, 1'b1);
    chk("emp_pp", RW'(cnt0), RW'(1));
    idle(1'b1);

    // Random mix around the full boundary
    for (int i = 0; i < 80; i++) begin
      logic [XLEN-1:0] pc;
      pc = $urandom() & 32'hFFFF_FFFC;
      cycle(($urandom_range(0, 3) != 0), ($urandom_range(0, 7) != 0),
            ($urandom_range(0, 2) == 0), 1'b0, pc,
            ($urandom_range(0, 1) != 0) ? pc + 32'd4 : $urandom(),
            $urandom(), 5'($urandom_range(0, 31)), $urandom());
    end

    // Asynchronous reset mid-stream
    for (int i = 0; i < 3; i++) push_ev(32'h7000 + 32'(i * 4), 32'h7004 + 32'(i * 4), 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_valid", RW'(v1), RW'(0));
    chk("mrst_count", RW'(cnt0), RW'(0));
    chk("mrst_empty", RW'(empty1), RW'(1));
    chk("mrst_ovf", RW'(ovf1), RW'(0));
    chk("mrst_data", rec0, '0);
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    check_state();
    push_ev(32'h8000, 32'h8004, 1'b0);
    chk("mrst_seq", RW'(seq0), RW'(0));
    idle(1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/retire_trace_buffer.md
# retire_trace_buffer

Parametrised retire-trace capture buffer for the RISC-V CPU verification environment. It samples one retire record per cycle from the core's observation signals: PC, next PC, instruction, rd and ALU/result. Each record is tagged with a sequence number and a taken-flow flag, and the records are held in a DEPTH-entry FIFO that the testbench drains through a valid/ready port. Full-buffer behaviour is selectable: drop the newest record, or overwrite the oldest. Every lost record is counted.

## Interface
- XLEN, 32: width of PC, next PC and result fields.
- DEPTH, 16: FIFO entries; a power of two, at least 2.
- SEQ_W, 16: sequence-number width; wraps modulo 2^SEQ_W.
- OVERWRITE, 0: 0 = drop new record when full; 1 = overwrite oldest record when full.

Ports:
- clk  in  1  clock; everything is on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- enable  in  1  capture enable; when low, cap_valid is ignored.
- clear  in  1  synchronous flush.
- cap_valid  in  1  retire event this cycle.
- cap_pc  in  XLEN  retiring PC.
- cap_next_pc  in  XLEN  next PC.
- cap_ins  in  32  instruction word.
- cap_rd  in  5  destination register index.
- cap_result  in  XLEN  ALU/memory result.
- out_valid  out  1  head record is available.
- out_ready  in  1  consumer accepts the head record.
- out_seq  out  SEQ_W  head sequence number.
- out_pc, out_next_pc, out_result  out  XLEN  head fields.
- out_ins  out  32  head instruction.
- out_rd  out  5  head rd.
- out_taken  out  1  head taken-flow flag.
- count  out  $clog2(DEPTH)+1  occupancy.
- full, empty  out  1  status flags.
- overflow_cnt  out  16  count of lost records; saturates at 16'hFFFF.

## Operation
- Event: cap_valid & enable. Each event consumes one sequence number, seq_cnt, which then increments whether the record is stored or dropped. Drops therefore appear as gaps in out_seq.
- Record contents: {seq_cnt, cap_pc, cap_next_pc, cap_ins, cap_rd, cap_result, taken}.
  - taken = (cap_next_pc != cap_pc + 4), computed modulo 2^XLEN.
- Storage: register array with write pointer wp, read pointer rp and counter cnt. Pointers wrap modulo DEPTH.
- Outputs are first-word-fall-through: out_* = mem[rp], out_valid = (cnt != 0), empty = (cnt == 0), full = (cnt == DEPTH), count = cnt.
- Pop: out_valid & out_ready.
  - rp advances and cnt decrements.
  - out_ready while empty has no effect.
- Push when not full: write mem[wp], advance wp, increment cnt.
- Event when full with a pop in the same cycle: push and pop both proceed, cnt is unchanged and nothing is lost.
- Event when full with no pop:
  - OVERWRITE=0: record discarded; overflow_cnt += 1.
  - OVERWRITE=1: write mem[wp], advance both wp and rp, cnt stays DEPTH, overflow_cnt += 1. The oldest record is lost.
- Push and pop in the same cycle while empty: the pop is ignored (out_valid is 0). The record is stored with cnt = 1 and no bypass.
- clear: wp, rp, cnt, seq_cnt and overflow_cnt go to 0. Clear overrides any push or pop in the same cycle, and an event in that cycle is discarded without counting.
- overflow_cnt saturates and does not wrap.

## Timing
- Reset (async assert, deassert synchronised by the environment):
  - wp, rp, cnt, seq_cnt and overflow_cnt are 0.
  - out_valid=0, empty=1, full=0, count=0.
  - out_* data is 0, because the array resets to 0.
- Reset mid-operation discards all contents immediately.
- Capture latency: an event at edge N is visible on out_* and out_valid after edge N, i.e. in cycle N+1.
- The head updates after the pop edge. There is no combinational path from out_ready to out_valid or data. The path from cap_* to out_* is registered only.
- Throughput: one push and one pop per cycle sustained.

## Test plan
- Reset then idle: out_valid=0, empty=1, count=0, overflow_cnt=0. Five events with pc=0x100,0x104,… and next_pc=pc+4, with out_ready=0 -> count=5, seq 0..4 drained in order, out_taken=0 on all.
- Branch flag: pc=0x200, next_pc=0x240 -> out_taken=1. pc=0xFFFFFFFC, next_pc=0x0 -> out_taken=0 (wrap).
- OVERWRITE=0, DEPTH=16: 20 events with no drain -> full=1, overflow_cnt=4, drained seq 0..15, next event gets seq 20.
- OVERWRITE=1, DEPTH=16: 20 events with no drain -> overflow_cnt=4, drained seq 4..19 in order.
- Full with simultaneous event and pop for 10 cycles -> count stays 16, overflow_cnt unchanged, no seq gap. enable=0 with cap_valid=1 -> no push, seq_cnt unchanged.
- clear asserted in the same cycle as an event and a pop with count=7 -> next cycle count=0, empty=1, overflow_cnt=0, next stored record has seq 0. rst_n pulsed low mid-stream -> all outputs at reset values.
